flash_arbiter: RTL and testbench
================================

# flash_arbiter

Schedules and shares the single SPI byte master between the flash write engine (WREN/SE/RDSR/PP sequencer) and the flash read engine. Each engine takes one complete operation at a time from a one-entry command slot. Arbitration is round-robin. A granted engine owns the byte master until its operation-end signal, after which a fixed idle gap is inserted. A watchdog forces release if an operation hangs.

## Interface
- GAP_CYC, 4, idle cycles between end of one grant and start of the next (≥1)
- TIMEOUT_CYC, 200_000_000, max cycles a grant may last (covers 3 s sector erase at 50 MHz)
- TO_W, 28, width of watchdog counter
- Reset is rst_n, asynchronous, active-low; the clock is clk.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_cmd_vld / wr_cmd_rdy  in/out  1/1  upstream write-command handshake
- wr_cmd_addr  in  24  flash address for write
- rd_cmd_vld / rd_cmd_rdy  in/out  1/1  upstream read-command handshake
- rd_cmd_addr  in  24  flash address for read
- wren  out  1  1-cycle start pulse to write engine
- wradress  out  24  address for write engine, valid with wren
- wr_req, wr_finish  in  1  write engine byte request / transaction end
- wr_din  in  8  write engine byte
- wr_end  in  1  write operation finished (wrdone or fail≠0)
- rden  out  1  1-cycle start pulse to read engine
- rdaddress  out  24  address for read engine, valid with rden
- rd_req, rd_finish  in  1  read engine byte request / transaction end
- rd_din  in  8  read engine byte
- rd_end  in  1  read operation finished
- req, finish  out  1  to byte master
- din  out  8  to byte master
- spi_done  in  1  byte complete from master
- spi_dout  in  8  received byte from master
- wr_spi_done / rd_spi_done  out  1  spi_done routed to owner only
- wr_spi_dout / rd_spi_dout  out  8  spi_dout routed to owner, else 0
- busy  out  1  state ≠ IDLE
- owner  out  2  00 none, 01 write, 10 read
- timeout  out  1  1-cycle pulse on watchdog release

## Operation
- Command slots: one entry each. rdy = ~pending. Accept on vld&rdy: latch addr, set pending. Acceptance is allowed in any state.
- States:
  - IDLE: if any pending, choose per round-robin and go to GRANT_WR or GRANT_RD. On that same edge, register wren/rden=1, wradress/rdaddress=slot addr, clear the slot's pending bit, zero the watchdog, and update last_grant.
  - GRANT_x: mux x's req/din/finish to the master. Route spi_done/spi_dout to x only. The other engine sees done=0, dout=0.
    - On x_end, go to GAP.
    - On watchdog==TIMEOUT_CYC-1, go to GAP and pulse timeout.
    - x_end takes priority if both occur in the same cycle, and no timeout pulse is issued.
  - GAP: req=finish=din=0. Count GAP_CYC cycles, then go to IDLE.
- Round-robin: if both slots are pending, grant the one ≠ last_grant. last_grant resets to read, so write wins first.
- Muxing is combinational from registered state. Outside GRANT states, req/finish/din are 0.
- The non-owner's req is ignored, never queued.
- Reset mid-operation: everything returns to reset values, and pending commands are lost.

## Timing
- Reset values: wr_cmd_rdy=1, rd_cmd_rdy=1, wren=0, rden=0, wradress=0, rdaddress=0, req=0, finish=0, din=0, all routed done/dout=0, busy=0, owner=00, timeout=0.
- Latency: vld&rdy at edge N with arbiter in IDLE → pending during cycle N..N+1 → start pulse high for the single cycle following edge N+1. Owner/busy update on the same edge N+1.
- Start pulse is exactly 1 cycle.
- x_end at edge M → req muxing stops from cycle M+1. Next start pulse no earlier than edge M+GAP_CYC+1.
- rdy falls the cycle after acceptance and rises the cycle after the slot is granted.
- Watchdog counts every GRANT cycle. Width is TO_W bits and never wraps, because release occurs at TIMEOUT_CYC-1.

## Structure
- Shared param.v adds the state codes (S_IDLE, S_GRANT_WR, S_GRANT_RD, S_GAP) and owner codes (OWN_NONE/WR/RD).
- One sub-module, flash_cmd_slot (24-bit one-entry holding register with vld/rdy, pending, and clear), is instantiated twice.

## Test plan
- Single write: wr_cmd addr 0x012345 → wren pulse with wradress=0x012345 2 cycles after accept. owner=01. wr_req/wr_din=0x06 appear on req/din. rd_spi_done stays 0.
- Both commands in the same cycle from reset → write granted first. After wr_end + 4 gap cycles, rden with the read address. owner sequence 01→00→10.
- Back-to-back: second write arrives while first granted → rdy=1 accepts it. Start is held until the gap ends. Third write while pending → wr_cmd_rdy=0.
- Fairness: write and read continuously pending → grants alternate W,R,W,R.
- Watchdog (TIMEOUT_CYC=100): grant, never assert rd_end → timeout pulse at grant cycle 100, then owner=00 and busy drops after the gap. rd_end coincident with the last count → no timeout pulse.
- Reset asserted during GRANT_WR with a read pending → all outputs return to reset values, rd_cmd_rdy=1, and no rden after reset release.

Source files
------------

// File: rtl/flash_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// flash_arbiter_pkg
// Shared definitions for the flash SPI byte-master arbiter:
//   - address/data widths of the command slots and byte lanes
//   - arbiter state encoding (S_IDLE, S_GRANT_WR, S_GRANT_RD, S_GAP)
//   - owner codes driven on the owner output (OWN_NONE/WR/RD)
//   - pickWrite(): the round-robin decision used in S_IDLE
// No ports; imported by flash_cmd_slot and flash_arbiter.
// ---------------------------------------------------------------------------
package flash_arbiter_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_GRANT_WR = 2'b01,
    S_GRANT_RD = 2'b10,
    S_GAP      = 2'b11
  } arbState_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_WR   = 2'b01;
  localparam logic [1:0] OWN_RD   = 2'b10;

  // Write wins when it is the only requester, or when both are pending and
  // the previous grant did not go to the write engine.
  function automatic logic pickWrite(input logic       wrPending,
                                     input logic       rdPending,
                                     input logic [1:0] lastGrant);
    return wrPending & (~rdPending | (lastGrant != OWN_WR));
  endfunction

endpackage

// File: rtl/flash_cmd_slot.sv
// ---------------------------------------------------------------------------
// flash_cmd_slot
// One-entry command holding register. A command is accepted on vld_i & rdy_o,
// which latches the address and sets pending. The arbiter clears pending with
// clr_i on the edge where it grants the command to an engine.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   vld_i / rdy_o     upstream handshake (rdy_o = ~pending)
//   addr_i            upstream address, latched on acceptance
//   clr_i             drop the held command (grant taken)
//   pending_o         a command is held
//   addr_o            held address
// ---------------------------------------------------------------------------
module flash_cmd_slot
  import flash_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              clr_i,
  output logic              rdy_o,
  output logic              pending_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic              pending_q;
  logic [ADDR_W-1:0] addr_q;

  // Holding register: clear has priority, although clear only ever arrives
  // while the slot is full, when no new command can be accepted anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      addr_q    <= '0;
    end else if (clr_i) begin
      pending_q <= 1'b0;
    end else if (vld_i && !pending_q) begin
      pending_q <= 1'b1;
      addr_q    <= addr_i;
    end
  end

  assign rdy_o     = ~pending_q;
  assign pending_o = pending_q;
  assign addr_o    = addr_q;

endmodule

// File: rtl/flash_arbiter.sv
// ---------------------------------------------------------------------------
// flash_arbiter
// Shares the single SPI byte master between the flash write engine and the
// flash read engine. Each engine has a one-entry command slot; pending
// commands are granted round-robin. The owner keeps the byte master until its
// operation-end strobe, then a GAP_CYC idle gap follows. A watchdog releases
// a grant that lasts TIMEOUT_CYC cycles and pulses timeout_o.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   wr_cmd_vld_i/rdy_o/addr_i          write command handshake + address
//   rd_cmd_vld_i/rdy_o/addr_i          read command handshake + address
//   wren_o, wradress_o                 1-cycle write start pulse + address
//   wr_req_i, wr_finish_i, wr_din_i    write engine byte-master requests
//   wr_end_i                           write operation finished
//   rden_o, rdaddress_o                1-cycle read start pulse + address
//   rd_req_i, rd_finish_i, rd_din_i    read engine byte-master requests
//   rd_end_i                           read operation finished
//   req_o, finish_o, din_o             muxed requests to the byte master
//   spi_done_i, spi_dout_i             byte master completion + received byte
//   wr_spi_done_o/dout_o               completion routed to write engine
//   rd_spi_done_o/dout_o               completion routed to read engine
//   busy_o, owner_o, timeout_o         status
// ---------------------------------------------------------------------------
module flash_arbiter
  import flash_arbiter_pkg::*;
#(
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 200_000_000,
  parameter int TO_W        = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_cmd_vld_i,
  output logic              wr_cmd_rdy_o,
  input  logic [ADDR_W-1:0] wr_cmd_addr_i,
  input  logic              rd_cmd_vld_i,
  output logic              rd_cmd_rdy_o,
  input  logic [ADDR_W-1:0] rd_cmd_addr_i,
  output logic              wren_o,
  output logic [ADDR_W-1:0] wradress_o,
  input  logic              wr_req_i,
  input  logic              wr_finish_i,
  input  logic [DATA_W-1:0] wr_din_i,
  input  logic              wr_end_i,
  output logic              rden_o,
  output logic [ADDR_W-1:0] rdaddress_o,
  input  logic              rd_req_i,
  input  logic              rd_finish_i,
  input  logic [DATA_W-1:0] rd_din_i,
  input  logic              rd_end_i,
  output logic              req_o,
  output logic              finish_o,
  output logic [DATA_W-1:0] din_o,
  input  logic              spi_done_i,
  input  logic [DATA_W-1:0] spi_dout_i,
  output logic              wr_spi_done_o,
  output logic              rd_spi_done_o,
  output logic [DATA_W-1:0] wr_spi_dout_o,
  output logic [DATA_W-1:0] rd_spi_dout_o,
  output logic              busy_o,
  output logic [1:0]        owner_o,
  output logic              timeout_o
);

  localparam int              GAP_W    = $clog2(GAP_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  arbState_t         state_q, state_d;
  logic              wrPending, rdPending;
  logic [ADDR_W-1:0] wrSlotAddr, rdSlotAddr;
  logic              grantWr, grantRd, wdogExpire;
  logic              wren_q, rden_q, timeout_q;
  logic [ADDR_W-1:0] wradress_q, rdaddress_q;
  logic [TO_W-1:0]   wdogCnt_q;
  logic [GAP_W-1:0]  gapCnt_q;
  logic [1:0]        lastGrant_q;

  flash_cmd_slot u_wrSlot (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld_i     (wr_cmd_vld_i),
    .addr_i    (wr_cmd_addr_i),
    .clr_i     (grantWr),
    .rdy_o     (wr_cmd_rdy_o),
    .pending_o (wrPending),
    .addr_o    (wrSlotAddr)
  );

  flash_cmd_slot u_rdSlot (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld_i     (rd_cmd_vld_i),
    .addr_i    (rd_cmd_addr_i),
    .clr_i     (grantRd),
    .rdy_o     (rd_cmd_rdy_o),
    .pending_o (rdPending),
    .addr_o    (rdSlotAddr)
  );

  // State register of the arbitration FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Besides the next state it flags the grant edge (which
  // clears the slot and fires the start pulse) and a watchdog release. An
  // engine's end strobe is checked first so a coincident expiry is not
  // reported as a timeout.
  always_comb begin
    state_d    = state_q;
    grantWr    = 1'b0;
    grantRd    = 1'b0;
    wdogExpire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wrPending || rdPending) begin
          if (pickWrite(wrPending, rdPending, lastGrant_q)) begin
            grantWr = 1'b1;
            state_d = S_GRANT_WR;
          end else begin
            grantRd = 1'b1;
            state_d = S_GRANT_RD;
          end
        end
      end
      S_GRANT_WR: begin
        if (wr_end_i) begin
          state_d = S_GAP;
        end else if (wdogCnt_q == TO_LAST) begin
          state_d    = S_GAP;
          wdogExpire = 1'b1;
        end
      end
      S_GRANT_RD: begin
        if (rd_end_i) begin
          state_d = S_GAP;
        end else if (wdogCnt_q == TO_LAST) begin
          state_d    = S_GAP;
          wdogExpire = 1'b1;
        end
      end
      S_GAP: begin
        if (gapCnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered side effects of the FSM: start pulses and their addresses,
  // the timeout pulse (high in the first gap cycle after a forced release),
  // the watchdog and gap counters, and the round-robin history. The start
  // addresses hold their last value between grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wren_q      <= 1'b0;
      rden_q      <= 1'b0;
      timeout_q   <= 1'b0;
      wradress_q  <= '0;
      rdaddress_q <= '0;
      wdogCnt_q   <= '0;
      gapCnt_q    <= '0;
      lastGrant_q <= OWN_RD;
    end else begin
      wren_q    <= grantWr;
      rden_q    <= grantRd;
      timeout_q <= wdogExpire;
      if (grantWr) begin
        wradress_q <= wrSlotAddr;
      end
      if (grantRd) begin
        rdaddress_q <= rdSlotAddr;
      end
      if (grantWr || grantRd) begin
        wdogCnt_q   <= '0;
        lastGrant_q <= grantWr ? OWN_WR : OWN_RD;
      end else if ((state_q == S_GRANT_WR || state_q == S_GRANT_RD) &&
                   wdogCnt_q != TO_LAST) begin
        wdogCnt_q <= wdogCnt_q + TO_W'(1);
      end
      if (state_q == S_GAP && gapCnt_q != GAP_LAST) begin
        gapCnt_q <= gapCnt_q + GAP_W'(1);
      end else begin
        gapCnt_q <= '0;
      end
    end
  end

  // Output logic: the owner's request lines go to the byte master and the
  // master's completion goes back to the owner only. Everything is zero
  // outside the grant states, so a non-owner request is simply dropped.
  always_comb begin
    req_o         = 1'b0;
    finish_o      = 1'b0;
    din_o         = '0;
    wr_spi_done_o = 1'b0;
    rd_spi_done_o = 1'b0;
    wr_spi_dout_o = '0;
    rd_spi_dout_o = '0;
    owner_o       = OWN_NONE;
    busy_o        = (state_q != S_IDLE);
    case (state_q)
      S_GRANT_WR: begin
        req_o         = wr_req_i;
        finish_o      = wr_finish_i;
        din_o         = wr_din_i;
        wr_spi_done_o = spi_done_i;
        wr_spi_dout_o = spi_dout_i;
        owner_o       = OWN_WR;
      end
      S_GRANT_RD: begin
        req_o         = rd_req_i;
        finish_o      = rd_finish_i;
        din_o         = rd_din_i;
        rd_spi_done_o = spi_done_i;
        rd_spi_dout_o = spi_dout_i;
        owner_o       = OWN_RD;
      end
      default: begin
        owner_o = OWN_NONE;
      end
    endcase
  end

  assign wren_o      = wren_q;
  assign rden_o      = rden_q;
  assign wradress_o  = wradress_q;
  assign rdaddress_o = rdaddress_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// ---------------------------------------------------------------------------
// tb_flash_arbiter
// Directed bench for flash_arbiter with GAP_CYC=4 and TIMEOUT_CYC=100.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_flash_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrCmdVld = 1'b0, rdCmdVld = 1'b0;
  logic [23:0] wrCmdAddr = '0, rdCmdAddr = '0;
  logic        wrReq = 1'b0, wrFinish = 1'b0, wrEnd = 1'b0;
  logic [7:0]  wrDin = '0;
  logic        rdReq = 1'b0, rdFinish = 1'b0, rdEnd = 1'b0;
  logic [7:0]  rdDin = '0;
  logic        spiDone = 1'b0;
  logic [7:0]  spiDout = '0;

  logic        wrCmdRdy, rdCmdRdy, wren, rden, req, finish, busy, timeout;
  logic [23:0] wradress, rdaddress;
  logic [7:0]  din, wrSpiDout, rdSpiDout;
  logic        wrSpiDone, rdSpiDone;
  logic [1:0]  owner;

  int checks = 0;
  int failures = 0;

  flash_arbiter #(.GAP_CYC(4), .TIMEOUT_CYC(100), .TO_W(28)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_cmd_vld_i  (wrCmdVld),
    .wr_cmd_rdy_o  (wrCmdRdy),
    .wr_cmd_addr_i (wrCmdAddr),
    .rd_cmd_vld_i  (rdCmdVld),
    .rd_cmd_rdy_o  (rdCmdRdy),
    .rd_cmd_addr_i (rdCmdAddr),
    .wren_o        (wren),
    .wradress_o    (wradress),
    .wr_req_i      (wrReq),
    .wr_finish_i   (wrFinish),
    .wr_din_i      (wrDin),
    .wr_end_i      (wrEnd),
    .rden_o        (rden),
    .rdaddress_o   (rdaddress),
    .rd_req_i      (rdReq),
    .rd_finish_i   (rdFinish),
    .rd_din_i      (rdDin),
    .rd_end_i      (rdEnd),
    .req_o         (req),
    .finish_o      (finish),
    .din_o         (din),
    .spi_done_i    (spiDone),
    .spi_dout_i    (spiDout),
    .wr_spi_done_o (wrSpiDone),
    .rd_spi_done_o (rdSpiDone),
    .wr_spi_dout_o (wrSpiDout),
    .rd_spi_dout_o (rdSpiDout),
    .busy_o        (busy),
    .owner_o       (owner),
    .timeout_o     (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic [23:0] wa,
                               input logic rv, input logic [23:0] ra);
    wrCmdVld  = wv;
    wrCmdAddr = wa;
    rdCmdVld  = rv;
    rdCmdAddr = ra;
  endtask

  task automatic clearEngines();
    wrReq = 1'b0; wrFinish = 1'b0; wrEnd = 1'b0; wrDin = '0;
    rdReq = 1'b0; rdFinish = 1'b0; rdEnd = 1'b0; rdDin = '0;
    spiDone = 1'b0; spiDout = '0;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);
    clearEngines();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic bad;
    logic found;

    // ---------------- reset values ----------------
    resetDut();
    checkOutput("rst_wr_rdy", 32'(wrCmdRdy), 32'd1);
    checkOutput("rst_rd_rdy", 32'(rdCmdRdy), 32'd1);
    checkOutput("rst_start", 32'({wren, rden, timeout}), 32'd0);
    checkOutput("rst_addr", 32'(wradress | rdaddress), 32'd0);
    checkOutput("rst_master", 32'({req, finish, din}), 32'd0);
    checkOutput("rst_route", 32'({wrSpiDone, rdSpiDone, wrSpiDout, rdSpiDout}), 32'd0);
    checkOutput("rst_status", 32'({busy, owner}), 32'd0);

    // ---------------- single write ----------------
    applyStimulus(1'b1, 24'h012345, 1'b0, 24'h0);
    tick();
    applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);
    checkOutput("w1_rdy_low", 32'(wrCmdRdy), 32'd0);
    checkOutput("w1_no_start_yet", 32'({wren, busy}), 32'd0);
    tick();
    checkOutput("w1_wren", 32'(wren), 32'd1);
    checkOutput("w1_wradress", 32'(wradress), 32'h012345);
    checkOutput("w1_owner", 32'(owner), 32'd1);
    checkOutput("w1_busy", 32'(busy), 32'd1);
    checkOutput("w1_rdy_back", 32'(wrCmdRdy), 32'd1);
    wrReq = 1'b1; wrDin = 8'h06; spiDone = 1'b1; spiDout = 8'hA5;
    rdDin = 8'hFF;
    #1;
    checkOutput("w1_req", 32'(req), 32'd1);
    checkOutput("w1_din", 32'(din), 32'h06);
    checkOutput("w1_wr_done", 32'({wrSpiDone, wrSpiDout}), 32'h1A5);
    checkOutput("w1_rd_route", 32'({rdSpiDone, rdSpiDout}), 32'd0);
    wrReq = 1'b0; rdReq = 1'b1;
    #1;
    checkOutput("w1_nonowner_req", 32'(req), 32'd0);
    tick();
    checkOutput("w1_wren_pulse", 32'(wren), 32'd0);
    wrFinish = 1'b1;
    #1;
    checkOutput("w1_finish", 32'(finish), 32'd1);
    wrEnd = 1'b1; wrReq = 1'b1;
    tick();
    wrEnd = 1'b0;
    checkOutput("w1_gap_master", 32'({req, finish, din}), 32'd0);
    checkOutput("w1_gap_owner", 32'({busy, owner}), 32'b100);
    tick(); tick(); tick();
    checkOutput("w1_gap4_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("w1_idle", 32'(busy), 32'd0);
    clearEngines();

    // ---------------- both commands from reset ----------------
    resetDut();
    applyStimulus(1'b1, 24'hABCDEF, 1'b1, 24'h100200);
    tick();
    applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);
    checkOutput("b_rdys_low", 32'({wrCmdRdy, rdCmdRdy}), 32'd0);
    tick();
    checkOutput("b_first_w", 32'({wren, rden, owner}), 32'b1001);
    checkOutput("b_wradress", 32'(wradress), 32'hABCDEF);
    checkOutput("b_rdys", 32'({wrCmdRdy, rdCmdRdy}), 32'b10);
    wrEnd = 1'b1;
    tick();
    wrEnd = 1'b0;
    checkOutput("b_gap_owner", 32'(owner), 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rden !== 1'b0 || owner !== 2'b00) bad = 1'b1;
    end
    checkOutput("b_gap_held", 32'(bad), 32'd0);
    tick();
    checkOutput("b_rden", 32'({rden, owner}), 32'b110);
    checkOutput("b_rdaddress", 32'(rdaddress), 32'h100200);
    checkOutput("b_rd_rdy", 32'(rdCmdRdy), 32'd1);
    rdEnd = 1'b1;
    tick();
    rdEnd = 1'b0;
    checkOutput("b_rd_released", 32'(owner), 32'd0);
    tick(); tick(); tick(); tick();
    checkOutput("b_idle", 32'(busy), 32'd0);

    // ---------------- back-to-back writes ----------------
    applyStimulus(1'b1, 24'h000111, 1'b0, 24'h0);
    tick();
    applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);
    tick();
    checkOutput("bb_first_grant", 32'({wren, wradress}), 32'h1000111);
    applyStimulus(1'b1, 24'h000222, 1'b0, 24'h0);
    checkOutput("bb_rdy_during_grant", 32'(wrCmdRdy), 32'd1);
    tick();
    applyStimulus(1'b1, 24'h000333, 1'b0, 24'h0);
    checkOutput("bb_third_blocked", 32'(wrCmdRdy), 32'd0);
    tick();
    applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);
    wrEnd = 1'b1;
    tick();
    wrEnd = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (wren !== 1'b0) bad = 1'b1;
      tick();
    end
    if (wren !== 1'b0) bad = 1'b1;
    checkOutput("bb_start_held", 32'(bad), 32'd0);
    tick();
    checkOutput("bb_second_grant", 32'({wren, wradress}), 32'h1000222);
    wrEnd = 1'b1;
    tick();
    wrEnd = 1'b0;
    tick(); tick(); tick(); tick();
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (wren !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checkOutput("bb_third_dropped", 32'(bad), 32'd0);

    // ---------------- fairness ----------------
    resetDut();
    applyStimulus(1'b1, 24'h0000AA, 1'b1, 24'h0000BB);
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        tick();
        if (wren === 1'b1 || rden === 1'b1) found = 1'b1;
      end
      checkOutput("fair_start_seen", 32'(found), 32'd1);
      checkOutput("fair_owner", 32'(owner), (k % 2 == 0) ? 32'd1 : 32'd2);
      wrEnd = 1'b1; rdEnd = 1'b1;
      tick();
      wrEnd = 1'b0; rdEnd = 1'b0;
    end
    applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);

    // ---------------- watchdog ----------------
    resetDut();
    applyStimulus(1'b0, 24'h0, 1'b1, 24'h00C0DE);
    tick();
    applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);
    tick();
    bad = 1'b0;
    for (int i = 0; i < 99; i++) begin
      if (owner !== 2'b10 || timeout !== 1'b0) bad = 1'b1;
      tick();
    end
    checkOutput("wd_grant_held", 32'(bad), 32'd0);
    checkOutput("wd_cycle100", 32'({owner, timeout}), 32'b100);
    tick();
    checkOutput("wd_timeout_pulse", 32'(timeout), 32'd1);
    checkOutput("wd_released", 32'({busy, owner}), 32'b100);
    tick();
    checkOutput("wd_pulse_width", 32'(timeout), 32'd0);
    tick(); tick();
    checkOutput("wd_gap_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("wd_idle", 32'(busy), 32'd0);

    applyStimulus(1'b0, 24'h0, 1'b1, 24'h00BEEF);
    tick();
    applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);
    tick();
    for (int i = 0; i < 99; i++) tick();
    rdEnd = 1'b1;
    tick();
    rdEnd = 1'b0;
    checkOutput("wd_coinc_no_pulse", 32'({timeout, owner, busy}), 32'b0001);
    tick();
    checkOutput("wd_coinc_no_late_pulse", 32'(timeout), 32'd0);
    tick(); tick(); tick();
    checkOutput("wd_coinc_idle", 32'(busy), 32'd0);

    // ---------------- reset mid-operation ----------------
    resetDut();
    applyStimulus(1'b1, 24'h0F0F0F, 1'b1, 24'h0A0A0A);
    tick();
    applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);
    tick();
    wrReq = 1'b1; wrDin = 8'h5A;
    #1;
    checkOutput("mr_granted", 32'({owner, req, rdCmdRdy}), 32'b0110);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_status", 32'({busy, owner, wren, rden, timeout}), 32'd0);
    checkOutput("mr_master", 32'({req, finish, din}), 32'd0);
    checkOutput("mr_rdys", 32'({wrCmdRdy, rdCmdRdy}), 32'b11);
    checkOutput("mr_addr", 32'(wradress | rdaddress), 32'd0);
    clearEngines();
    tick();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rden !== 1'b0 || wren !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checkOutput("mr_no_start_after", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
